// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction memory between the
// fetch unit and the program loader. BOOT lets only the loader in; RUN
// arbitrates per cycle, loader first, and turns fetch byte PCs into word
// indices with address-fault detection.
// Optional build macro IMEM_ARB_FAIR_EN: bounds how many consecutive loader
// wins a waiting fetch can suffer (STARVE) before fetch is forced through.
module imem_arbiter #(
    parameter logic [31:0] BASE   = 32'h0000_3000,
    parameter int          AW     = 10,
    parameter int          STARVE = 4
) (
    input  logic          Clk,
    input  logic          Clr,
    input  logic          FReq,
    input  logic [31:0]   FPC,
    output logic          FGnt,
    output logic          FValid,
    output logic [31:0]   FData,
    output logic          FErr,
    input  logic          LReq,
    input  logic [AW-1:0] LAddr,
    input  logic [31:0]   LData,
    input  logic          LDone,
    output logic          LGnt,
    output logic [AW-1:0] MemAddr,
    output logic          MemWe,
    output logic [31:0]   MemWData,
    input  logic [31:0]   MemRData,
    output logic          Booting
);

    localparam logic [0:0]  ST_BOOT = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;
    // One past the last byte address backed by memory, kept 33 bits wide so
    // a BASE near the top of the address space cannot wrap.
    localparam logic [32:0] LIMIT   = {1'b0, BASE} + (33'd4 << AW);

    logic [0:0]    state_q, state_d;
    logic          f_valid_q, f_valid_d;
    logic          f_err_q, f_err_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          l_gnt;
    logic          f_gnt;
    logic          fetch_fault;
    logic          fetch_forced;
    logic [31:0]   fpc_off;
    logic          unused_off_bits;

    // Byte offset from memory word 0; only the word-index bits reach memory.
    assign fpc_off         = FPC - BASE;
    assign unused_off_bits = ^{fpc_off[31:AW+2], fpc_off[1:0]};
    assign fetch_fault     = (FPC < BASE) || ({1'b0, FPC} >= LIMIT) ||
                             (FPC[1:0] != 2'b00);

`ifdef IMEM_ARB_FAIR_EN
    localparam int CW = $clog2(STARVE + 1);

    logic [CW-1:0] starve_q, starve_d;

    assign fetch_forced = (starve_q == CW'(STARVE)) && FReq;

    // Count loader wins that happened while fetch was waiting; any fetch
    // grant or any cycle without a fetch request starts the count over.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ST_RUN) begin
            if (!FReq || f_gnt) begin
                starve_d = '0;
            end else if (l_gnt) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    // Per-cycle grant: loader only while booting, loader-first in RUN unless
    // the fairness counter forces a waiting fetch through.
    always_comb begin
        l_gnt = 1'b0;
        f_gnt = 1'b0;
        if (state_q == ST_BOOT) begin
            l_gnt = LReq;
        end else if (LReq && !fetch_forced) begin
            l_gnt = 1'b1;
        end else if (FReq) begin
            f_gnt = 1'b1;
        end
    end

    // Memory port drive; a faulting fetch touches nothing, so the address
    // holds its last value just as on an idle cycle.
    always_comb begin
        mem_addr_d = mem_addr_q;
        if (l_gnt) begin
            mem_addr_d = LAddr;
        end else if (f_gnt && !fetch_fault) begin
            mem_addr_d = fpc_off[AW+1:2];
        end
    end

    // Next-state and response bookkeeping for the cycle after a fetch grant.
    always_comb begin
        state_d   = state_q;
        f_valid_d = f_gnt;
        f_err_d   = f_gnt && fetch_fault;
        if ((state_q == ST_BOOT) && LDone) begin
            state_d = ST_RUN;
        end
    end

    // State, response flags and held memory address.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= ST_BOOT;
            f_valid_q  <= 1'b0;
            f_err_q    <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            f_valid_q  <= f_valid_d;
            f_err_q    <= f_err_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign LGnt     = l_gnt;
    assign FGnt     = f_gnt;
    assign MemWe    = l_gnt;
    assign MemWData = l_gnt ? LData : 32'h0;
    assign MemAddr  = mem_addr_d;
    assign FValid   = f_valid_q;
    assign FErr     = f_err_q;
    assign FData    = (f_valid_q && !f_err_q) ? MemRData : 32'h0;
    assign Booting  = (state_q == ST_BOOT);

endmodule
